// File: rtl/npc_pkg.sv
// Shared constants and types for the issue scoreboard.
//   OP_SYSTEM : opcode of CSR / ecall instructions (serializing)
//   REG_ZERO  : architectural x0, never tracked
//   sb_state_e: issue FSM states
package npc_pkg;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [4:0] REG_ZERO  = 5'd0;
  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} sb_state_e;
endpackage

// File: rtl/rd_tag_fifo.sv
// Ordered FIFO of in-flight destination register tags.
// Ports:
//   clock_i, reset_i        : clock, async active-high reset
//   enq_i / enq_rd_i        : push a tag at tail
//   deq_i                   : pop head (caller guarantees legality)
//   flush_i / flush_keep_i  : trim tail to head' + min(keep, occupancy')
//   cmp_a_i / cmp_b_i       : tags compared against every live entry
//   excl_head_i             : drop the head entry from the compare
//   hit_a_o / hit_b_o       : any live entry matches cmp_a_i / cmp_b_i
//   head_rd_o               : tag at head
//   count_o, full_o, empty_o: occupancy and status
module rd_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enq_i,
  input  logic [4:0]       enq_rd_i,
  input  logic             deq_i,
  input  logic             flush_i,
  input  logic [PTR_W:0]   flush_keep_i,
  input  logic [4:0]       cmp_a_i,
  input  logic [4:0]       cmp_b_i,
  input  logic             excl_head_i,
  output logic             hit_a_o,
  output logic             hit_b_o,
  output logic [4:0]       head_rd_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [4:0]       mem_q [DEPTH];
  logic [PTR_W:0]   head_q, tail_q, head_d, tail_d, cnt_after, keep;
  logic [DEPTH-1:0] match_a, match_b;

  assign count_o   = tail_q - head_q;
  assign full_o    = (head_q[PTR_W] != tail_q[PTR_W]) &&
                     (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);
  assign empty_o   = (head_q == tail_q);
  assign head_rd_o = mem_q[head_q[PTR_W-1:0]];

  // An entry is live when its distance from head is below occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [PTR_W-1:0] idx;
    logic [PTR_W:0]   off;
    logic             live;
    assign idx  = PTR_W'(i);
    assign off  = {1'b0, idx - head_q[PTR_W-1:0]};
    assign live = (off < count_o) && !(excl_head_i && (off == '0));
    assign match_a[i] = live && (mem_q[i] == cmp_a_i);
    assign match_b[i] = live && (mem_q[i] == cmp_b_i);
  end
  assign hit_a_o = |match_a;
  assign hit_b_o = |match_b;

  // Flush trims relative to the post-retire head and clamps to what is left.
  always_comb begin
    head_d    = head_q + (PTR_W+1)'(deq_i);
    cnt_after = tail_q - head_d;
    keep      = (flush_keep_i > cnt_after) ? cnt_after : flush_keep_i;
    tail_d    = flush_i ? head_d + keep : tail_q + (PTR_W+1)'(enq_i);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (enq_i && !flush_i) mem_q[tail_q[PTR_W-1:0]] <= enq_rd_i;
  end
endmodule

// File: rtl/issue_scoreboard.sv
// Decode-to-execute issue controller. Tracks in-flight writers, stalls on
// RAW hazards, full tag FIFO or serializing ops, trims on jump flush.
// Ports: clock_i/reset_i (async active-high); decode id_*_i; ex_ready_i;
//   issue_valid_o/id_ready_o (comb); wb_valid_i/wb_rd_i in-order retire;
//   flush_i/flush_keep_i; inflight_o occupancy; stall_o perf tap.
// Config: ISSUE_SCOREBOARD_BYPASS_EN lets a dependent issue in the same
//   cycle its producer retires (needs EXU writeback forwarding).
module issue_scoreboard
  import npc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             id_valid_i,
  input  logic [6:0]       id_op_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_reg_wen_i,
  input  logic             ex_ready_i,
  output logic             issue_valid_o,
  output logic             id_ready_o,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             flush_i,
  input  logic [PTR_W:0]   flush_keep_i,
  output logic [PTR_W:0]   inflight_o,
  output logic             stall_o
);
  sb_state_e  state_q;
  logic       serial, hazard, deq, enq, excl, hit1, hit2, full, empty, issue;
  logic [4:0] head_rd;

  assign serial = (id_op_i == OP_SYSTEM);
  assign deq    = wb_valid_i && !empty && (wb_rd_i == head_rd);

`ifdef ISSUE_SCOREBOARD_BYPASS_EN
  assign excl = deq;
`else
  assign excl = 1'b0;
`endif

  assign hazard = (hit1 && id_rs1_i != REG_ZERO) || (hit2 && id_rs2_i != REG_ZERO);

  // A same-cycle retire frees a slot, so full only blocks without one.
  assign issue = !reset_i && id_valid_i && ex_ready_i && !hazard &&
                 !(full && !deq) && !flush_i && (state_q == RUN) &&
                 (!serial || empty);
  assign enq   = issue && id_reg_wen_i && (id_rd_i != REG_ZERO);

  assign issue_valid_o = issue;
  assign id_ready_o    = issue;
  assign stall_o       = !reset_i && id_valid_i && !issue;

  rd_tag_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .enq_i        (enq),
    .enq_rd_i     (id_rd_i),
    .deq_i        (deq),
    .flush_i      (flush_i),
    .flush_keep_i (flush_keep_i),
    .cmp_a_i      (id_rs1_i),
    .cmp_b_i      (id_rs2_i),
    .excl_head_i  (excl),
    .hit_a_o      (hit1),
    .hit_b_o      (hit2),
    .head_rd_o    (head_rd),
    .count_o      (inflight_o),
    .full_o       (full),
    .empty_o      (empty)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (id_valid_i && serial && !empty) state_q <= DRAIN;
        DRAIN:   if (empty || flush_i)              state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Retire must target the oldest in-flight writer.
  a_wb_order: assert property (@(posedge clock_i) disable iff (reset_i)
    wb_valid_i |-> (!empty && wb_rd_i == head_rd));
`endif
endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] SYS  = 7'b1110011;

  logic       clock = 1'b0, reset = 1'b1;
  logic       id_valid = 0, id_reg_wen = 0, ex_ready = 0, wb_valid = 0, flush = 0;
  logic [6:0] id_op = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
  logic [2:0] flush_keep = '0, inflight;
  logic       issue_valid, id_ready, stall;

  int n_tot = 0, n_pass = 0;

  issue_scoreboard dut (
    .clock_i(clock), .reset_i(reset),
    .id_valid_i(id_valid), .id_op_i(id_op), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rd_i(id_rd), .id_reg_wen_i(id_reg_wen), .ex_ready_i(ex_ready),
    .issue_valid_o(issue_valid), .id_ready_o(id_ready),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .flush_i(flush), .flush_keep_i(flush_keep),
    .inflight_o(inflight), .stall_o(stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic v; logic [6:0] op; logic [4:0] rs1, rs2, rd; logic wen, exr;
    logic wbv; logic [4:0] wbrd; logic fl; logic [2:0] fk;
    logic e_iss, e_stall; logic [2:0] e_infl;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(input logic v, input logic [6:0] op, input int rs1, rs2, rd,
                              input logic wen, exr, wbv, input int wbrd, input logic fl,
                              input int fk, input logic ei, es, input int ef);
    vec_t r;
    r.v = v; r.op = op; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
    r.wen = wen; r.exr = exr; r.wbv = wbv; r.wbrd = 5'(wbrd); r.fl = fl;
    r.fk = 3'(fk); r.e_iss = ei; r.e_stall = es; r.e_infl = 3'(ef);
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic drive(input vec_t r);
    id_valid = r.v; id_op = r.op; id_rs1 = r.rs1; id_rs2 = r.rs2; id_rd = r.rd;
    id_reg_wen = r.wen; ex_ready = r.exr; wb_valid = r.wbv; wb_rd = r.wbrd;
    flush = r.fl; flush_keep = r.fk;
  endtask

  task automatic idle();
    drive(mk(0, ADD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    // Test 1: write x1 then dependent read
    vq.push_back(mk(1, ADDI, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, ADD,  1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 1));
`ifdef ISSUE_SCOREBOARD_BYPASS_EN
    vq.push_back(mk(1, ADD,  1, 1, 2, 1, 1, 1, 1, 0, 0, 1, 0, 1));
    vq.push_back(mk(0, ADD,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
`else
    vq.push_back(mk(1, ADD,  1, 1, 2, 1, 1, 1, 1, 0, 0, 0, 1, 1));
    vq.push_back(mk(1, ADD,  1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 0, 0));
`endif
    vq.push_back(mk(0, ADD,  0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 1));
    // Test 3: x0 never enqueued or hazarded
    vq.push_back(mk(1, ADDI, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, ADD,  0, 0, 3, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, ADD,  0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 1));
    // Test 2: fill, full stall, retire frees slot same cycle
    for (int k = 1; k <= 4; k++) vq.push_back(mk(1, ADDI, 0, 0, k, 1, 1, 0, 0, 0, 0, 1, 0, k-1));
    vq.push_back(mk(1, ADD,  6, 7, 5, 1, 1, 0, 0, 0, 0, 0, 1, 4));
    vq.push_back(mk(1, ADD,  6, 7, 5, 1, 1, 1, 1, 0, 0, 1, 0, 4));
    for (int k = 2; k <= 5; k++) vq.push_back(mk(0, ADD, 0, 0, 0, 0, 1, 1, k, 0, 0, 0, 0, 6-k));
    vq.push_back(mk(1, ADDI, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));   // ex not ready
    // Test 4: flush keep 1, then flush with clamp and same-cycle retire
    for (int k = 5; k <= 7; k++) vq.push_back(mk(1, ADDI, 0, 0, k, 1, 1, 0, 0, 0, 0, 1, 0, k-5));
    vq.push_back(mk(0, ADD,  0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 3));
    vq.push_back(mk(1, ADD,  6, 6, 8, 1, 1, 0, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(1, ADDI, 0, 0, 9, 1, 1, 1, 5, 1, 4, 0, 1, 2));
    vq.push_back(mk(0, ADD,  0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, ADD,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // Test 5: CSR waits in DRAIN until empty, then one more cycle to RUN
    vq.push_back(mk(1, ADDI, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, ADDI, 0, 0, 2, 1, 1, 0, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(1, SYS,  0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 1, 2));
    vq.push_back(mk(1, SYS,  0, 0, 10, 1, 1, 1, 1, 0, 0, 0, 1, 2));
    vq.push_back(mk(1, SYS,  0, 0, 10, 1, 1, 1, 2, 0, 0, 0, 1, 1));
    vq.push_back(mk(1, SYS,  0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk(1, SYS,  0, 0, 10, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(0, ADD,  0, 0, 0, 0, 1, 1, 10, 0, 0, 0, 0, 1));

    // Reset: outputs held at zero even with a valid decode presented
    drive(mk(1, ADDI, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("rst issue", issue_valid, 0);
    chk("rst ready", id_ready, 0);
    chk("rst stall", stall, 0);
    chk("rst inflight", inflight, 0);
    idle();
    @(posedge clock); #1 reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i]);
      @(negedge clock);
      chk($sformatf("v%0d issue", i), issue_valid, vq[i].e_iss);
      chk($sformatf("v%0d ready", i), id_ready, vq[i].e_iss);
      chk($sformatf("v%0d stall", i), stall, vq[i].e_stall);
      chk($sformatf("v%0d inflight", i), inflight, vq[i].e_infl);
      @(posedge clock); #1;
    end

    // Test 6: async reset mid-DRAIN with three entries in flight
    for (int k = 1; k <= 3; k++) begin
      drive(mk(1, ADDI, 0, 0, k, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clock); #1;
    end
    drive(mk(1, SYS, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    chk("t6 pre stall", stall, 1);
    chk("t6 pre inflight", inflight, 3);
    @(posedge clock); #2;              // now in DRAIN
    chk("t6 drain issue", issue_valid, 0);
    reset = 1'b1; #1;
    chk("t6 rst issue", issue_valid, 0);
    chk("t6 rst ready", id_ready, 0);
    chk("t6 rst stall", stall, 0);
    chk("t6 rst inflight", inflight, 0);
    @(negedge clock); reset = 1'b0; #1;
    chk("t6 post issue", issue_valid, 1);
    chk("t6 post stall", stall, 0);
    @(posedge clock); #1;
    idle();
    chk("t6 post inflight", inflight, 1);
    drive(mk(0, ADD, 0, 0, 0, 0, 1, 1, 10, 0, 0, 0, 0, 0));
    @(posedge clock); #1;
    idle();
    chk("t6 end inflight", inflight, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
